// File: rtl/cla_operand_sequencer_if.sv
// Byte-in / result-out handshake bundle for cla_operand_sequencer.
// Ports: in_valid/in_ready/in_byte (byte stream), res_valid/res_ready/res_data (sum).
`timescale 1ns/1ps
interface cla_operand_sequencer_if #(
    parameter int BIT_NUMBER = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [7:0]            in_byte;
    logic                  res_valid;
    logic                  res_ready;
    logic [BIT_NUMBER:0]   res_data;

    // Byte source and result consumer side.
    modport master (
        output in_valid, in_byte, res_ready,
        input  in_ready, res_valid, res_data
    );

    // Sequencer side.
    modport slave (
        input  in_valid, in_byte, res_ready,
        output in_ready, res_valid, res_data
    );
endinterface

// File: rtl/cla_operand_sequencer.sv
// Byte-serial operand loader and sum capture around an external CLA adder.
// Ports: clk, rst_n, clr, io (slave handshake bundle), add_a/add_b out, add_s in, busy.
`timescale 1ns/1ps
module cla_operand_sequencer #(
    parameter int BIT_NUMBER = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    cla_operand_sequencer_if.slave io,
    output logic [BIT_NUMBER-1:0]  add_a,
    output logic [BIT_NUMBER-1:0]  add_b,
    input  logic [BIT_NUMBER:0]    add_s,
    output logic                   busy
);
    localparam int BYTES = BIT_NUMBER / 8;
    localparam int CW = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [CW-1:0] LAST = CW'(BYTES - 1);

    typedef enum logic [1:0] {
        LOAD_A,
        LOAD_B,
        SETTLE,
        RESULT
    } state_t;

    state_t                state;
    logic [CW-1:0]         cnt;
    logic [BIT_NUMBER-1:0] a_q;
    logic [BIT_NUMBER-1:0] b_q;
    logic [BIT_NUMBER:0]   res_q;
    logic                  res_v;
    logic                  xfer;

    assign io.in_ready  = (state == LOAD_A) || (state == LOAD_B);
    assign io.res_valid = res_v;
    assign io.res_data  = res_q;
    assign add_a        = a_q;
    assign add_b        = b_q;
    assign busy         = !((state == LOAD_A) && (cnt == '0));
    assign xfer         = io.in_valid && io.in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LOAD_A;
            cnt   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            res_q <= '0;
            res_v <= 1'b0;
        end else if (clr) begin
            state <= LOAD_A;
            cnt   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            res_q <= '0;
            res_v <= 1'b0;
        end else begin
            unique case (state)
                LOAD_A, LOAD_B: begin
                    if (xfer) begin
                        // Constant byte lanes keep the write free of
                        // variable part-selects.
                        for (int k = 0; k < BYTES; k++) begin
                            if (cnt == CW'(k)) begin
                                if (state == LOAD_A)
                                    a_q[8*k +: 8] <= io.in_byte;
                                else
                                    b_q[8*k +: 8] <= io.in_byte;
                            end
                        end
                        if (cnt == LAST) begin
                            cnt   <= '0;
                            state <= (state == LOAD_A) ? LOAD_B : SETTLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                SETTLE: begin
                    // Operands have been stable for a full cycle.
                    res_q <= add_s;
                    res_v <= 1'b1;
                    state <= RESULT;
                end
                RESULT: begin
                    if (io.res_ready) begin
                        res_v <= 1'b0;
                        state <= LOAD_A;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cla_operand_sequencer.sv
// Self-checking bench for cla_operand_sequencer (8-bit directed, 16-bit scoreboard).
// The adder is modelled here as a plain sum feeding add_s.
`timescale 1ns/1ps
module tb_cla_operand_sequencer;
    logic clk = 1'b0;
    logic rst_n;
    logic clr16;
    logic clr8;
    always #5 clk = ~clk;

    cla_operand_sequencer_if #(.BIT_NUMBER(16)) if16();
    cla_operand_sequencer_if #(.BIT_NUMBER(8))  if8();

    logic [15:0] a16, b16;
    logic [16:0] s16;
    logic        busy16;
    logic [7:0]  a8, b8;
    logic [8:0]  s8;
    logic        busy8;

    assign s16 = {1'b0, a16} + {1'b0, b16};
    assign s8  = {1'b0, a8} + {1'b0, b8};

    cla_operand_sequencer #(.BIT_NUMBER(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .clr(clr16), .io(if16),
        .add_a(a16), .add_b(b16), .add_s(s16), .busy(busy16)
    );
    cla_operand_sequencer #(.BIT_NUMBER(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .clr(clr8), .io(if8),
        .add_a(a8), .add_b(b8), .add_s(s8), .busy(busy8)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Reference model: bytes in arrival order, LSB first, A then B.
    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [16:0] s;
    } exp_t;
    exp_t       expq[$];
    logic [7:0] byteq[$];

    task automatic model_byte(input logic [7:0] v);
        exp_t e;
        int unsigned av, bv;
        byteq.push_back(v);
        if (byteq.size() == 4) begin
            av  = byteq[0] + 256 * byteq[1];
            bv  = byteq[2] + 256 * byteq[3];
            e.a = 16'(av);
            e.b = 16'(bv);
            e.s = 17'(av + bv);
            expq.push_back(e);
            byteq.delete();
        end
    endtask

    // Monitor: a handshake happens at the next edge whenever both are
    // high at the falling edge (inputs change only just after rising).
    always @(negedge clk) begin
        if (rst_n && !clr16 && if16.res_valid && if16.res_ready) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got %0h expected none",
                         if16.res_data);
            end else begin
                exp_t e;
                e = expq.pop_front();
                chk("res_data16", 64'(if16.res_data), 64'(e.s));
                chk("add_a16", 64'(a16), 64'(e.a));
                chk("add_b16", 64'(b16), 64'(e.b));
            end
        end
    end

    bit rr_rand = 1'b0;
    always @(posedge clk) begin
        if (rr_rand) begin
            #1;
            if16.res_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic send16(input logic [7:0] v, input int gap);
        int n = 0;
        if16.in_valid = 1'b1;
        if16.in_byte  = v;
        @(negedge clk);
        while (!if16.in_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!if16.in_ready) fail("send16_timeout");
        else model_byte(v);
        @(posedge clk);
        #1;
        if16.in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain16();
        int n = 0;
        while (expq.size() != 0 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL drain16: got %0d outstanding expected 0",
                     expq.size());
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        rst_n = 1'b0;
        clr16 = 1'b0;
        clr8  = 1'b0;
        if16.in_valid = 1'b0; if16.in_byte = '0; if16.res_ready = 1'b0;
        if8.in_valid  = 1'b0; if8.in_byte  = '0; if8.res_ready  = 1'b0;
        #12;
        chk("rst_in_ready16", 64'(if16.in_ready), 1);
        chk("rst_res_valid16", 64'(if16.res_valid), 0);
        chk("rst_res_data16", 64'(if16.res_data), 0);
        chk("rst_add_a16", 64'(a16), 0);
        chk("rst_add_b16", 64'(b16), 0);
        chk("rst_busy16", 64'(busy16), 0);
        chk("rst_in_ready8", 64'(if8.in_ready), 1);
        chk("rst_res_valid8", 64'(if8.res_valid), 0);
        #5 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 8-bit: FF + 01 back to back, exact latency.
        if8.res_ready = 1'b1;
        if8.in_valid  = 1'b1;
        if8.in_byte   = 8'hFF;
        @(posedge clk); #1;
        chk("b8_busy_after_a", 64'(busy8), 1);
        chk("b8_ready_load_b", 64'(if8.in_ready), 1);
        if8.in_byte = 8'h01;
        @(posedge clk); #1;
        if8.in_valid = 1'b0;
        @(negedge clk);
        chk("b8_ready_settle", 64'(if8.in_ready), 0);
        chk("b8_valid_settle", 64'(if8.res_valid), 0);
        chk("b8_add_a", 64'(a8), 64'h0FF);
        chk("b8_add_b", 64'(b8), 64'h001);
        @(posedge clk); #1;
        @(negedge clk);
        chk("b8_res_valid", 64'(if8.res_valid), 1);
        chk("b8_res_data", 64'(if8.res_data), 64'h100);
        @(posedge clk); #1;
        @(negedge clk);
        chk("b8_ready_after_hs", 64'(if8.in_ready), 1);
        chk("b8_valid_after_hs", 64'(if8.res_valid), 0);
        chk("b8_busy_after_hs", 64'(busy8), 0);
        @(posedge clk); #1;

        // 16-bit gapless.
        if16.res_ready = 1'b1;
        send16(8'h34, 0); send16(8'h12, 0);
        send16(8'hCD, 0); send16(8'hAB, 0);
        drain16();
        chk("hold_a16", 64'(a16), 64'h1234);
        chk("hold_b16", 64'(b16), 64'hABCD);
        repeat (4) send16(8'hFF, 0);
        drain16();

        // Input gaps: same operands as above.
        send16(8'h34, 1); send16(8'h12, 1);
        send16(8'hCD, 1); send16(8'hAB, 1);
        drain16();

        // Backpressure.
        if16.res_ready = 1'b0;
        send16(8'h10, 0); send16(8'h00, 0);
        send16(8'h20, 0); send16(8'h00, 0);
        @(posedge clk); #1;
        if16.in_valid = 1'b1;
        if16.in_byte  = 8'h55;
        repeat (5) begin
            @(negedge clk);
            chk("bp_res_valid", 64'(if16.res_valid), 1);
            chk("bp_res_data", 64'(if16.res_data), 64'h30);
            chk("bp_in_ready", 64'(if16.in_ready), 0);
            chk("bp_busy", 64'(busy16), 1);
        end
        @(posedge clk); #1;
        if16.in_valid  = 1'b0;
        if16.res_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_ready_after", 64'(if16.in_ready), 1);
        chk("bp_valid_after", 64'(if16.res_valid), 0);
        chk("bp_no_bytes_taken", 64'(busy16), 0);
        chk("bp_single_hs", 64'(expq.size()), 0);
        @(posedge clk); #1;

        // clr mid-LOAD_B with a byte presented in the same cycle.
        send16(8'h11, 0); send16(8'h22, 0); send16(8'h33, 0);
        clr16 = 1'b1;
        byteq.delete();
        if16.in_valid = 1'b1;
        if16.in_byte  = 8'h77;
        @(posedge clk); #1;
        clr16 = 1'b0;
        if16.in_valid = 1'b0;
        @(negedge clk);
        chk("clr_busy", 64'(busy16), 0);
        chk("clr_add_a", 64'(a16), 0);
        chk("clr_add_b", 64'(b16), 0);
        chk("clr_res_valid", 64'(if16.res_valid), 0);
        chk("clr_in_ready", 64'(if16.in_ready), 1);
        @(posedge clk); #1;
        send16(8'h01, 0); send16(8'h00, 0);
        send16(8'h02, 0); send16(8'h00, 0);
        drain16();

        // Randomized traffic with random gaps and result backpressure.
        rr_rand = 1'b1;
        for (int t = 0; t < 25; t++) begin
            for (int k = 0; k < 4; k++)
                send16(8'($urandom_range(0, 255)), $urandom_range(0, 2));
        end
        rr_rand = 1'b0;
        @(posedge clk); #2;
        if16.res_ready = 1'b1;
        drain16();

        // Async reset while holding a result.
        if16.res_ready = 1'b0;
        send16(8'h80, 0); send16(8'h90, 0);
        send16(8'h80, 0); send16(8'h90, 0);
        n = 0;
        while (!if16.res_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ar_in_result", 64'(if16.res_valid), 1);
        chk("ar_res_data", 64'(if16.res_data), 64'h12100);
        @(posedge clk);
        #3 rst_n = 1'b0;
        expq.delete();
        byteq.delete();
        #1;
        chk("ar_res_valid", 64'(if16.res_valid), 0);
        chk("ar_res_data0", 64'(if16.res_data), 0);
        chk("ar_add_a", 64'(a16), 0);
        chk("ar_add_b", 64'(b16), 0);
        chk("ar_in_ready", 64'(if16.in_ready), 1);
        @(negedge clk);
        #2 rst_n = 1'b1;
        if16.res_ready = 1'b1;
        @(posedge clk); #1;
        send16(8'h05, 0); send16(8'h00, 0);
        send16(8'h07, 0); send16(8'h00, 0);
        drain16();
        chk("ar_final_sum", 64'(if16.res_data), 64'h0000C);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
